// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port RAM and the code that drives it.
package ram_pkg;

    // Same-address, same-edge collision policy for the read port.
    typedef enum logic {
        WRITE_FIRST,
        READ_FIRST
    } rdw_mode_e;

    localparam int BYTE_W = 8;

    // Number of byte lanes in a word of the given width.
    function automatic int num_bytes(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline: STAGES-deep chain carrying valid, error flag and data.
// Data registers only load alongside a valid read so the output word holds
// between reads; valid and error are cleared on reset so in-flight reads vanish.
module ram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_in,
    input  logic              err_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              vld_out,
    output logic              err_out,
    output logic [DATA_W-1:0] data_out
);

    logic              vld_p0;
    logic              err_p0;
    logic [DATA_W-1:0] data_p0;

    // Stage p0: capture the collision-resolved read word at the request edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            err_p0  <= 1'b0;
            data_p0 <= '0;
        end else begin
            vld_p0 <= vld_in;
            err_p0 <= vld_in & err_in;
            if (vld_in) begin
                data_p0 <= data_in;
            end
        end
    end

    if (STAGES >= 2) begin : g_p1
        logic              vld_p1;
        logic              err_p1;
        logic [DATA_W-1:0] data_p1;

        // Stage p1: pure retiming register, no further memory lookup.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p1  <= 1'b0;
                err_p1  <= 1'b0;
                data_p1 <= '0;
            end else begin
                vld_p1 <= vld_p0;
                err_p1 <= err_p0;
                if (vld_p0) begin
                    data_p1 <= data_p0;
                end
            end
        end

        assign vld_out  = vld_p1;
        assign err_out  = err_p1;
        assign data_out = data_p1;
    end else begin : g_p0_out
        assign vld_out  = vld_p0;
        assign err_out  = err_p0;
        assign data_out = data_p0;
    end

endmodule

// File: rtl/ram_dp_param.sv
// Simple dual-port RAM: one byte-enabled write port, one read port with
// 1- or 2-cycle latency, selectable read-during-write policy, and range
// error flags for addresses at or beyond DEPTH.
module ram_dp_param
    import ram_pkg::*;
#(
    parameter int        DATA_W   = 32,
    parameter int        DEPTH    = 16,
    parameter int        ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int        RD_LAT   = 1,
    parameter rdw_mode_e RDW_MODE = WRITE_FIRST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_enb,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/BYTE_W-1:0] wr_be,
    output logic                     wr_err,
    input  logic                     rd_enb,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     rd_err
);

    localparam int              NBYTES  = num_bytes(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Elaboration-time sanity checks on the configuration.
    if (DATA_W % BYTE_W != 0) begin : g_chk_data_w
        $error("ram_dp_param: DATA_W must be a multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_rd_lat
        $error("ram_dp_param: RD_LAT must be 1 or 2");
    end

    // Replace the lanes of old_w selected by be with the matching lanes of new_w.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NBYTES-1:0] be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) begin
                res[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_hit;
    logic              rd_collide;
    logic [DATA_W-1:0] rd_word;

    // With a power-of-two DEPTH every address is in range and these fold away.
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_hit      = wr_enb && wr_in_range;
    assign rd_collide  = wr_hit && rd_enb && rd_in_range && (wr_addr == rd_addr);

    // Storage array: byte-merged write into the addressed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_hit) begin
            mem[wr_addr] <= byte_merge(mem[wr_addr], wr_data, wr_be);
        end
    end

    // Read word selection: out-of-range reads return zero; a same-address
    // write either forwards its merged word or is ignored, per RDW_MODE.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
            if (rd_collide && (RDW_MODE == WRITE_FIRST)) begin
                rd_word = byte_merge(mem[rd_addr], wr_data, wr_be);
            end
        end
    end

    // Write error flag: one-cycle pulse after an out-of-range write request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_enb && !wr_in_range;
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld_in   (rd_enb),
        .err_in   (!rd_in_range),
        .data_in  (rd_word),
        .vld_out  (rd_valid),
        .err_out  (rd_err),
        .data_out (rd_data)
    );

endmodule
